// File: rtl/cv32e40p_ft_supervisor_if.sv
// Command channel of the fault-tolerance supervisor.
//
// Handshake: a command is transferred on a rising clk edge where both
// cmd_valid_i and cmd_ready_o are 1. The requester holds cmd_valid_i and
// the payload (cmd_op_i, cmd_unit_i, cmd_lane_i) stable until that edge.
// Completion is reported later by a one-cycle cmd_done_o pulse. cmd_err_o
// is meaningful only while cmd_done_o is 1.
//
// Signals:
//   cmd_valid_i  request valid
//   cmd_ready_o  supervisor can accept this cycle
//   cmd_op_i     0=FORCE, 1=RELEASE, 2=CLEAR unit counters, 3=CLEAR fatal
//   cmd_unit_i   target unit index
//   cmd_lane_i   target lane 0..2
//   cmd_done_o   one-cycle completion pulse
//   cmd_err_o    command failed (qualified by cmd_done_o)
interface cv32e40p_ft_supervisor_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [3:0] cmd_unit_i;
    logic [1:0] cmd_lane_i;
    logic       cmd_done_o;
    logic       cmd_err_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_unit_i, cmd_lane_i,
        input  cmd_ready_o, cmd_done_o, cmd_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_unit_i, cmd_lane_i,
        output cmd_ready_o, cmd_done_o, cmd_err_o
    );
endinterface

// File: rtl/cv32e40p_ft_supervisor.sv
// Fault-tolerance supervisor for the TMR cv32e40p *_ft blocks.
// Counts detected/corrected errors per unit (saturating), raises a sticky
// fatal flag when a unit has two or more broken lanes, and forces/releases
// individual lanes through a command channel with confirmation and timeout.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   err_detected_i    per-unit error detected pulses
//   err_corrected_i   per-unit error corrected pulses
//   is_broken_i       per-unit, per-lane broken status
//   set_broken_o      per-unit, per-lane broken force (level)
//   cmd               command channel (slave side)
//   rd_unit_i         counter read index
//   rd_det_cnt_o      detected count of rd_unit_i, one cycle later
//   rd_cor_cnt_o      corrected count of rd_unit_i, one cycle later
//   fatal_o           sticky fatal flag
//   fatal_unit_o      lowest unit index that raised fatal
//   dbg_state_o       command FSM state (0 IDLE, 1 APPLY, 2 CONFIRM, 3 DONE)
module cv32e40p_ft_supervisor #(
    parameter int N_UNITS         = 4,
    parameter int CNT_BITS        = 16,
    parameter int CONFIRM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_UNITS-1:0]       err_detected_i,
    input  logic [N_UNITS-1:0]       err_corrected_i,
    input  logic [N_UNITS-1:0][2:0]  is_broken_i,
    output logic [N_UNITS-1:0][2:0]  set_broken_o,
    cv32e40p_ft_supervisor_if.slave  cmd,
    input  logic [3:0]               rd_unit_i,
    output logic [CNT_BITS-1:0]      rd_det_cnt_o,
    output logic [CNT_BITS-1:0]      rd_cor_cnt_o,
    output logic                     fatal_o,
    output logic [3:0]               fatal_unit_o,
    output logic [1:0]               dbg_state_o
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_APPLY   = 2'd1;
    localparam logic [1:0] S_CONFIRM = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [1:0] OP_FORCE   = 2'd0;
    localparam logic [1:0] OP_RELEASE = 2'd1;
    localparam logic [1:0] OP_CLR_CNT = 2'd2;
    localparam logic [1:0] OP_CLR_FAT = 2'd3;

    localparam int TW = $clog2(CONFIRM_TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    logic [1:0]                r_state;
    logic [1:0]                w_next;
    logic                      r_ready;
    logic [3:0]                r_unit;
    logic [1:0]                r_lane;
    logic                      r_err;
    logic [TW-1:0]             r_timer;
    logic [N_UNITS-1:0][2:0]   r_sb;
    logic [CNT_BITS-1:0]       r_det [N_UNITS];
    logic [CNT_BITS-1:0]       r_cor [N_UNITS];
    logic [CNT_BITS-1:0]       r_rd_det;
    logic [CNT_BITS-1:0]       r_rd_cor;
    logic [CNT_BITS-1:0]       w_rd_det;
    logic [CNT_BITS-1:0]       w_rd_cor;
    logic                      r_fatal;
    logic [3:0]                r_fatal_unit;
    logic [N_UNITS-1:0]        w_fat_vec;
    logic [3:0]                w_fat_low;
    logic                      w_accept;
    logic                      w_bad;
    logic                      w_rel;
    logic                      w_clr_cnt;
    logic                      w_clr_fat;
    logic                      w_confirm;

    // Unit compared on 5 bits so N_UNITS=16 does not collapse to 0.
    assign w_accept  = (r_state == S_IDLE) && r_ready && cmd.cmd_valid_i;
    assign w_bad     = ({1'b0, cmd.cmd_unit_i} >= 5'(N_UNITS)) || (cmd.cmd_lane_i == 2'd3);
    assign w_rel     = w_accept && !w_bad && (cmd.cmd_op_i == OP_RELEASE);
    assign w_clr_cnt = w_accept && !w_bad && (cmd.cmd_op_i == OP_CLR_CNT);
    assign w_clr_fat = w_accept && !w_bad && (cmd.cmd_op_i == OP_CLR_FAT);

    always_comb begin
        w_confirm = 1'b0;
        w_rd_det  = '0;
        w_rd_cor  = '0;
        w_fat_low = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            for (int l = 0; l < 3; l++) begin
                if (r_unit == 4'(u) && r_lane == 2'(l)) w_confirm = is_broken_i[u][l];
            end
            if (rd_unit_i == 4'(u)) begin
                w_rd_det = r_det[u];
                w_rd_cor = r_cor[u];
            end
            // Majority of the three lane flags == two or more broken.
            w_fat_vec[u] = (is_broken_i[u][0] & is_broken_i[u][1]) |
                           (is_broken_i[u][0] & is_broken_i[u][2]) |
                           (is_broken_i[u][1] & is_broken_i[u][2]);
        end
        for (int u = N_UNITS - 1; u >= 0; u--) begin
            if (w_fat_vec[u]) w_fat_low = 4'(u);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = (w_bad || cmd.cmd_op_i != OP_FORCE) ? S_DONE : S_APPLY;
            S_APPLY:   w_next = S_CONFIRM;
            S_CONFIRM: if (w_confirm || r_timer == TW'(1)) w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_unit  <= '0;
            r_lane  <= '0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            // Ready is registered so it stays low throughout reset.
            r_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_unit <= cmd.cmd_unit_i;
                r_lane <= cmd.cmd_lane_i;
                r_err  <= w_bad;
            end
            if (r_state == S_APPLY) r_timer <= TW'(CONFIRM_TIMEOUT);
            if (r_state == S_CONFIRM && !w_confirm) begin
                r_timer <= r_timer - TW'(1);
                if (r_timer == TW'(1)) r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            for (int u = 0; u < N_UNITS; u++) begin
                for (int l = 0; l < 3; l++) begin
                    if (r_state == S_APPLY && r_unit == 4'(u) && r_lane == 2'(l))
                        r_sb[u][l] <= 1'b1;
                    else if (w_rel && cmd.cmd_unit_i == 4'(u) && cmd.cmd_lane_i == 2'(l))
                        r_sb[u][l] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < N_UNITS; u++) begin
                r_det[u] <= '0;
                r_cor[u] <= '0;
            end
            r_rd_det <= '0;
            r_rd_cor <= '0;
        end else begin
            for (int u = 0; u < N_UNITS; u++) begin
                // Clear wins over a coincident error pulse.
                if (w_clr_cnt && cmd.cmd_unit_i == 4'(u)) begin
                    r_det[u] <= '0;
                    r_cor[u] <= '0;
                end else begin
                    if (err_detected_i[u] && r_det[u] != CNT_MAX) r_det[u] <= r_det[u] + 1'b1;
                    if (err_corrected_i[u] && r_cor[u] != CNT_MAX) r_cor[u] <= r_cor[u] + 1'b1;
                end
            end
            r_rd_det <= w_rd_det;
            r_rd_cor <= w_rd_cor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fatal      <= 1'b0;
            r_fatal_unit <= '0;
        end else if (w_clr_fat) begin
            // A persisting condition re-raises fatal on the following edge.
            r_fatal      <= 1'b0;
            r_fatal_unit <= '0;
        end else if (!r_fatal && |w_fat_vec) begin
            r_fatal      <= 1'b1;
            r_fatal_unit <= w_fat_low;
        end
    end

    assign set_broken_o    = r_sb;
    assign cmd.cmd_ready_o = r_ready;
    assign cmd.cmd_done_o  = (r_state == S_DONE);
    assign cmd.cmd_err_o   = (r_state == S_DONE) && r_err;
    assign rd_det_cnt_o    = r_rd_det;
    assign rd_cor_cnt_o    = r_rd_cor;
    assign fatal_o         = r_fatal;
    assign fatal_unit_o    = r_fatal_unit;
    assign dbg_state_o     = r_state;
endmodule

// File: tb/tb_cv32e40p_ft_supervisor.sv
module tb_cv32e40p_ft_supervisor;
  localparam int EXP_W = 1;

  logic              clk;
  logic              rst_n;
  logic [3:0]        err_det;
  logic [3:0]        err_cor;
  logic [3:0][2:0]   is_broken;
  logic [3:0][2:0]   set_broken;
  logic [3:0][2:0]   set_broken2;
  logic [3:0]        rd_unit;
  logic [15:0]       rd_det;
  logic [15:0]       rd_cor;
  logic [3:0]        rd_det2;
  logic [3:0]        rd_cor2;
  logic              fatal;
  logic              fatal2;
  logic [3:0]        fatal_unit;
  logic [3:0]        fatal_unit2;
  logic [1:0]        dbg_state;
  logic [1:0]        dbg_state2;

  logic [3:0][2:0]   exp_sb;
  logic [EXP_W-1:0]  exp_q[$];
  int                n_checks;
  int                n_fail;

  cv32e40p_ft_supervisor_if sif ();
  cv32e40p_ft_supervisor_if sif2 ();

  cv32e40p_ft_supervisor #(.N_UNITS(4), .CNT_BITS(16), .CONFIRM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .err_detected_i(err_det), .err_corrected_i(err_cor),
    .is_broken_i(is_broken), .set_broken_o(set_broken),
    .cmd(sif),
    .rd_unit_i(rd_unit), .rd_det_cnt_o(rd_det), .rd_cor_cnt_o(rd_cor),
    .fatal_o(fatal), .fatal_unit_o(fatal_unit), .dbg_state_o(dbg_state)
  );

  // Narrow-counter instance for saturation.
  cv32e40p_ft_supervisor #(.N_UNITS(4), .CNT_BITS(4), .CONFIRM_TIMEOUT(16)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .err_detected_i(err_det), .err_corrected_i(err_cor),
    .is_broken_i(is_broken), .set_broken_o(set_broken2),
    .cmd(sif2),
    .rd_unit_i(rd_unit), .rd_det_cnt_o(rd_det2), .rd_cor_cnt_o(rd_cor2),
    .fatal_o(fatal2), .fatal_unit_o(fatal_unit2), .dbg_state_o(dbg_state2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each done pulse pops the expected error flag
  always @(negedge clk) begin
    if (rst_n && sif.cmd_done_o) begin
      if (exp_q.size() == 0) check("done_unexpected", 32'(exp_q.size()), 32'd1);
      else check("done_err", 32'(sif.cmd_err_o), 32'(exp_q.pop_front()));
    end
  end

  // drivers
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] unit, input logic [1:0] lane,
                          input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    sif.cmd_valid_i = 1'b1;
    sif.cmd_op_i    = op;
    sif.cmd_unit_i  = unit;
    sif.cmd_lane_i  = lane;
    while (!sif.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(n < 50), 32'd1);
    exp_q.push_back(exp_err);
    @(posedge clk);
    #1;
    sif.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", 32'(n < 100), 32'd1);
  endtask

  task automatic wait_done_cycles(input string tag, input int exp_cyc);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (sif.cmd_done_o) got = 1'b1;
    end
    check(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sb"},    32'(set_broken), 32'd0);
    check({tag, "_ready"}, 32'(sif.cmd_ready_o), 32'd0);
    check({tag, "_done"},  32'(sif.cmd_done_o), 32'd0);
    check({tag, "_err"},   32'(sif.cmd_err_o), 32'd0);
    check({tag, "_fatal"}, 32'({fatal, fatal_unit}), 32'd0);
    check({tag, "_rd"},    {rd_det, rd_cor}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int cyc;
    bit got;
    logic [1:0] op;
    logic [3:0] unit;
    logic [1:0] lane;
    logic       bad;

    n_checks = 0;
    n_fail   = 0;
    exp_sb   = '0;
    rst_n    = 1'b0;
    err_det  = '0;
    err_cor  = '0;
    is_broken = '0;
    rd_unit  = 4'd0;
    sif.cmd_valid_i  = 1'b0;
    sif.cmd_op_i     = '0;
    sif.cmd_unit_i   = '0;
    sif.cmd_lane_i   = '0;
    sif2.cmd_valid_i = 1'b0;
    sif2.cmd_op_i    = '0;
    sif2.cmd_unit_i  = '0;
    sif2.cmd_lane_i  = '0;
    #2;
    check_all_zero("rst_init");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", 32'(sif.cmd_ready_o), 32'd1);

    // counting: unit 2, 5 detected and 3 corrected
    rd_unit = 4'd2;
    err_det[2] = 1'b1;
    err_cor[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 err_cor[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 err_det[2] = 1'b0;
    @(posedge clk);
    #1;
    check("cnt_det2", 32'(rd_det), 32'd5);
    check("cnt_cor2", 32'(rd_cor), 32'd3);
    rd_unit = 4'd9;
    @(posedge clk);
    #1;
    check("rd_out_of_range", {rd_det, rd_cor}, 32'd0);

    // saturation: 20 pulses on unit 0
    err_det[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1 err_det[0] = 1'b0;
    rd_unit = 4'd0;
    @(posedge clk);
    #1;
    check("sat_det_4bit", 32'(rd_det2), 32'd15);
    check("nosat_det_16bit", 32'(rd_det), 32'd20);

    // CLEAR unit 2 with a coincident detected error
    @(negedge clk);
    err_det[2] = 1'b1;
    send_cmd(2'd2, 4'd2, 2'd0, 1'b0);
    err_det[2] = 1'b0;
    rd_unit = 4'd2;
    @(posedge clk);
    #1;
    check("clr_det2", 32'(rd_det), 32'd0);
    check("clr_cor2", 32'(rd_cor), 32'd0);
    wait_done();

    // FORCE success: confirm arrives in the 3rd CONFIRM cycle
    send_cmd(2'd0, 4'd1, 2'd0, 1'b0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (sif.cmd_done_o) got = 1'b1;
      else if (cyc == 4) is_broken[1][0] = 1'b1;
    end
    check("force_latency", 32'(cyc), 32'd5);
    exp_sb[1][0] = 1'b1;
    check("force_sb", 32'(set_broken), 32'(exp_sb));

    // FORCE timeout
    is_broken[1][0] = 1'b0;
    send_cmd(2'd0, 4'd1, 2'd0, 1'b1);
    wait_done_cycles("timeout_latency", 18);
    check("timeout_sb", 32'(set_broken), 32'(exp_sb));
    send_cmd(2'd1, 4'd1, 2'd0, 1'b0);
    wait_done();
    exp_sb[1][0] = 1'b0;
    check("release_sb", 32'(set_broken), 32'(exp_sb));

    // illegal commands
    send_cmd(2'd0, 4'd7, 2'd0, 1'b1);
    wait_done();
    send_cmd(2'd0, 4'd0, 2'd3, 1'b1);
    wait_done();
    send_cmd(2'd1, 4'd7, 2'd1, 1'b1);
    wait_done();
    check("illegal_sb", 32'(set_broken), 32'(exp_sb));

    // fatal
    @(negedge clk);
    is_broken[3] = 3'b101;
    is_broken[1] = 3'b011;
    @(negedge clk);
    check("fatal_set", 32'({fatal, fatal_unit}), 32'h11);
    send_cmd(2'd3, 4'd0, 2'd0, 1'b0);
    check("fatal_clr_drop", 32'(fatal), 32'd0);
    @(posedge clk);
    #1;
    check("fatal_reassert", 32'({fatal, fatal_unit}), 32'h11);
    wait_done();
    is_broken = '0;
    repeat (2) @(negedge clk);
    check("fatal_sticky", 32'(fatal), 32'd1);
    send_cmd(2'd3, 4'd0, 2'd0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check("fatal_cleared", 32'({fatal, fatal_unit}), 32'd0);

    // random RELEASE / CLEAR traffic over two forced lanes
    is_broken[0][2] = 1'b1;
    is_broken[3][1] = 1'b1;
    send_cmd(2'd0, 4'd0, 2'd2, 1'b0);
    wait_done();
    send_cmd(2'd0, 4'd3, 2'd1, 1'b0);
    wait_done();
    exp_sb[0][2] = 1'b1;
    exp_sb[3][1] = 1'b1;
    check("pre_rand_sb", 32'(set_broken), 32'(exp_sb));
    for (int i = 0; i < 12; i++) begin
      op   = 2'($urandom_range(1, 3));
      unit = 4'($urandom_range(0, 7));
      lane = 2'($urandom_range(0, 3));
      bad  = (unit >= 4'd4) || (lane == 2'd3);
      send_cmd(op, unit, lane, bad);
      wait_done();
      if (!bad && op == 2'd1) exp_sb[unit[1:0]][lane] = 1'b0;
      check("rand_sb", 32'(set_broken), 32'(exp_sb));
    end
    check("rand_fatal", 32'(fatal), 32'd0);

    // reset in the middle of CONFIRM
    is_broken = '0;
    send_cmd(2'd0, 4'd2, 2'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_confirm_state", 32'(dbg_state), 32'd2);
    check("mid_confirm_sb", 32'(set_broken[2][1]), 32'd1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_sb = '0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(sif.cmd_ready_o), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_sb", 32'(set_broken), 32'(exp_sb));
    repeat (20) @(negedge clk);
    check("no_stray_done", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cv32e40p_ft_supervisor.md
Name: cv32e40p_ft_supervisor

Overview:
Central fault-tolerance supervisor. It sits at the far end of the set_broken_i / is_broken_o / err_detected_o / err_corrected_o interface of the triplicated (TMR) cv32e40p *_ft blocks. It counts detected and corrected errors per protected unit, flags a fatal condition when a unit can no longer vote, and drives set_broken per lane from a command handshake with confirmation and timeout.

Parameters:
N_UNITS, 4, number of FT units monitored (1..16)
CNT_BITS, 16, width of per-unit saturating error counters
CONFIRM_TIMEOUT, 16, cycles allowed for is_broken to confirm a FORCE command (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
err_detected_i  in  N_UNITS  per-unit err_detected_o from FT blocks
err_corrected_i  in  N_UNITS  per-unit err_corrected_o from FT blocks
is_broken_i  in  N_UNITS x 3  per-unit, per-lane is_broken_o
set_broken_o  out  N_UNITS x 3  per-unit, per-lane set_broken_i drive (level)
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted this cycle
cmd_op_i  in  2  0=FORCE lane broken, 1=RELEASE lane, 2=CLEAR unit counters, 3=CLEAR fatal
cmd_unit_i  in  4  target unit index
cmd_lane_i  in  2  target lane 0..2
cmd_done_o  out  1  one-cycle pulse: command completed
cmd_err_o  out  1  valid with cmd_done_o: command failed
rd_unit_i  in  4  counter read index
rd_det_cnt_o  out  CNT_BITS  detected count of rd_unit_i, registered
rd_cor_cnt_o  out  CNT_BITS  corrected count of rd_unit_i, registered
fatal_o  out  1  sticky: some unit has >=2 broken lanes
fatal_unit_o  out  4  lowest unit index that raised fatal

Behaviour:
- Reset (async, rst_n=0): all outputs 0, counters 0, FSM in IDLE, set_broken_o all 0.
- Counters: every cycle, det[u] += err_detected_i[u] and cor[u] += err_corrected_i[u], saturating at 2^CNT_BITS-1 (no wrap). A CLEAR of unit u zeroes det[u]/cor[u] for that cycle; a coincident error is dropped, so the count ends at 0.
- Readout: rd_*_cnt_o <= counters[rd_unit_i]; 1-cycle latency. Out-of-range rd_unit_i (>= N_UNITS) returns 0.
- Fatal: a unit with popcount(is_broken_i[u]) >= 2 sets fatal_o. fatal_unit_o latches the lowest such index on the first rising event only. Both are cleared only by reset or the CLEAR fatal op. If the condition still holds when CLEAR fatal completes, fatal re-asserts on the next cycle.
- FSM states: IDLE, APPLY, CONFIRM, DONE.
- IDLE: cmd_ready_o=1. Capture the command when cmd_valid_i=1; the handshake completes in that cycle.
  - Invalid unit (>= N_UNITS) or lane==3 -> DONE with err.
  - FORCE -> APPLY.
  - RELEASE, CLEAR unit, CLEAR fatal -> take effect in the capture cycle (registered effect next edge) -> DONE, no err.
- APPLY (1 cycle): set_broken_o[u][l] <= 1. Timer loads CONFIRM_TIMEOUT. Go to CONFIRM.
- CONFIRM: when is_broken_i[u][l]=1 -> DONE, no err. Otherwise decrement the timer; on reaching 0 -> DONE with err, with set_broken_o left asserted.
- DONE (1 cycle): cmd_done_o=1, cmd_err_o as determined. Return to IDLE.
- cmd_ready_o is 0 in every state except IDLE. cmd_valid_i outside IDLE is ignored; the requester holds it until ready.
- set_broken_o bits change only by FORCE/RELEASE or reset. RELEASE of a lane not forced is legal and a no-op.
- FORCE on an already-forced lane still runs APPLY/CONFIRM and normally confirms on the first CONFIRM cycle.
- Reset mid-command aborts it. No done pulse is generated and all set_broken_o go to 0.

Test Plan:
- Reset: rst_n low mid-CONFIRM -> all outputs 0 immediately (async); FSM IDLE, cmd_ready_o=1 after release.
- Counting: err_detected_i[2]=1 for 5 cycles, err_corrected_i[2]=1 for 3 cycles, rd_unit_i=2 -> rd_det_cnt_o=5, rd_cor_cnt_o=3. CNT_BITS=4 with 20 pulses -> 15.
- FORCE success: FORCE unit1 lane0; is_broken_i[1][0] rises 3 cycles after APPLY -> set_broken_o[1][0]=1; cmd_done_o pulses with cmd_err_o=0, 5 cycles after accept.
- FORCE timeout: is_broken_i never rises, CONFIRM_TIMEOUT=16 -> cmd_done_o with cmd_err_o=1 after 16 CONFIRM cycles; set_broken_o[1][0] stays 1. Then RELEASE -> set_broken_o[1][0]=0, done with no error.
- Fatal: is_broken_i[3]=3'b101 and [1]=3'b011 in the same cycle -> fatal_o=1, fatal_unit_o=1. CLEAR fatal while the condition persists -> fatal_o drops for one cycle, then reasserts. After the condition is removed and CLEAR fatal is issued -> fatal_o stays 0.
- Illegal command: cmd_unit_i=7 with N_UNITS=4, or cmd_lane_i=3 -> done with cmd_err_o=1, no set_broken_o change. CLEAR unit 2 coincident with err_detected_i[2]=1 -> det[2]=0.
